dom_and_share_feeder: RTL and testbench
=======================================

Name: dom_and_share_feeder

Overview:
- Upstream stage for the 2-share, 8-bit DOM AND gadget.
- Accepts unmasked operand pairs over a valid/ready handshake and splits each into two Boolean shares using masks from an internal 32-bit LFSR. The same LFSR word also supplies the gadget's fresh randomness Z.
- Sequences the gadget's one-cycle register latency: shares stay stable through the cycle in which the gadget output is valid, and that cycle is flagged to downstream logic.

Parameters:
- WIDTH, 8, operand/share width; legal range 1..10 (3*WIDTH <= 32).
- SEED_DEFAULT, 32'hC0FF_EE01, LFSR value after reset; must be non-zero.
- SEED_SUBST, 32'h1357_9BDF, value loaded when a zero seed is written; must be non-zero.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset.
- seed_valid_i  in  1  load seed_i into LFSR this cycle.
- seed_i  in  32  new LFSR seed.
- in_valid_i  in  1  operand pair valid.
- in_ready_o  out  1  block can accept operand pair.
- x_i  in  WIDTH  unmasked operand X.
- y_i  in  WIDTH  unmasked operand Y.
- X0_o, X1_o  out  WIDTH  shares of X, to gadget X0_i/X1_i.
- Y0_o, Y1_o  out  WIDTH  shares of Y, to gadget Y0_i/Y1_i.
- Z_o  out  WIDTH  fresh randomness, to gadget Z_i.
- dom_q_valid_o  out  1  gadget Q0/Q1 outputs correspond to the current op this cycle.
- busy_o  out  1  an operation is in ISSUE or HOLD.

Interface rule: one clock (clk_i); reset (rst_i) is synchronous and active-high.

Behaviour:
- Reset (rst_i high at a rising edge):
  - state=IDLE; lfsr=SEED_DEFAULT.
  - All share outputs and Z_o = 0.
  - in_ready_o=0 while rst_i is high; dom_q_valid_o=0; busy_o=0.
- FSM states: IDLE, ISSUE, HOLD.
- Accept condition: in_valid_i & in_ready_o.
  - in_ready_o = (state==IDLE | state==HOLD) & !seed_valid_i & !rst_i.
- On accept, from the current lfsr value L:
  - mx=L[WIDTH-1:0], my=L[2*WIDTH-1:WIDTH], mz=L[3*WIDTH-1:2*WIDTH].
  - Registered: X0=x_i^mx, X1=mx, Y0=y_i^my, Y1=my, Z=mz.
  - lfsr <= L advanced 32 steps (unrolled). No operation ever reuses mask bits.
- LFSR: Galois, right-shifting, feedback mask 32'h80200003 (x^32+x^22+x^2+x+1).
  - One step: lsb=l[0]; l=l>>1; if lsb, l^=mask.
  - LFSR changes only on accept or seed load.
- Transitions:
  - IDLE -accept-> ISSUE.
  - ISSUE -> HOLD, unconditionally. The gadget samples cross-domain terms at the end of ISSUE.
  - HOLD -accept-> ISSUE (back-to-back; throughput 1 op per 2 cycles).
  - HOLD -no accept-> IDLE.
- Output timing:
  - Latency: accept at edge t; shares valid from cycle t+1; dom_q_valid_o=1 in cycle t+2 (HOLD) only.
  - Shares and Z are stable across ISSUE and HOLD.
  - In IDLE, outputs retain their last values (no extra toggling).
- Seed load:
  - seed_valid_i=1 at an edge loads lfsr <= (seed_i==0 ? SEED_SUBST : seed_i).
  - Seed load has priority over advancement; no accept occurs in that cycle.
  - An in-flight op (ISSUE/HOLD) completes with its already-registered shares.
- Reset mid-operation aborts: state returns to IDLE, dom_q_valid_o drops next cycle, outputs are cleared.
- LFSR never holds zero (non-zero seeds plus zero substitution).
- busy_o = (state!=IDLE).

Decomposition:
- Shared package dom_pkg:
  - LFSR_W=32, LFSR_POLY=32'h80200003.
  - State enum {IDLE, ISSUE, HOLD}.
  - Function lfsr_adv32(L) returning L advanced 32 steps.
- One sub-module: dom_lfsr32 (seed load with zero substitution, advance enable, 32-bit state output).

Test Plan:
- Reset, then x_i=8'hA5, y_i=8'h3C accepted at cycle 1 -> cycle 2: X0=8'hA4, X1=8'h01, Y0=8'hD2, Y1=8'hEE, Z=8'hFF; cycle 3: dom_q_valid_o=1, gadget Q0^Q1=8'h24.
- Back-to-back stream, in_valid_i held 1 for 6 ops -> in_ready_o alternates 1/0, one accept every 2 cycles, dom_q_valid_o pulses every 2nd cycle. Each Q0^Q1 = x&y; the second op's masks equal lfsr_adv32(SEED_DEFAULT) bytes.
- seed_valid_i=1 with seed_i=0 while in_valid_i=1 -> no accept that cycle, lfsr=32'h1357_9BDF; next op has X1=8'hDF, Y1=8'h9B, Z=8'h57.
- Seed load during HOLD -> the in-flight op's shares are unchanged and dom_q_valid_o still asserts; the next op's masks come from the new seed.
- rst_i asserted in ISSUE -> next cycle all outputs 0, busy_o=0, dom_q_valid_o never asserts for the aborted op; the LFSR restarts from SEED_DEFAULT (the first op again yields X1=8'h01).
- Random regression, 10k ops against a reference model -> share XOR equals operand every op, X1/Y1/Z match the model LFSR bytes, no stall beyond the 2-cycle cadence.

Source files
------------

// File: rtl/dom_pkg.sv
// Shared definitions for the DOM AND share feeder: LFSR constants, FSM state
// encoding and the 32-step unrolled Galois LFSR advance.
package dom_pkg;

    localparam int          LFSR_W    = 32;
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Right-shifting Galois LFSR advanced 32 steps, so every op gets fresh bits.
    function automatic logic [LFSR_W-1:0] lfsr_adv32(input logic [LFSR_W-1:0] l);
        logic [LFSR_W-1:0] v;
        v = l;
        for (int i = 0; i < 32; i++) begin
            if (v[0]) begin
                v = (v >> 1) ^ LFSR_POLY;
            end else begin
                v = v >> 1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/dom_lfsr32.sv
// 32-bit mask LFSR with seed load (zero seeds substituted) and a per-op
// 32-step advance.
module dom_lfsr32
    import dom_pkg::*;
#(
    parameter logic [31:0] SEED_DEFAULT = 32'hC0FF_EE01,
    parameter logic [31:0] SEED_SUBST   = 32'h1357_9BDF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              seed_valid_i,
    input  logic [31:0]       seed_i,
    input  logic              adv_i,
    output logic [LFSR_W-1:0] state_o
);

    logic [LFSR_W-1:0] lfsr_r;

    // LFSR state: seed load wins over advance; a zero seed would lock the LFSR.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_r <= SEED_DEFAULT;
        end else if (seed_valid_i) begin
            lfsr_r <= (seed_i == 32'h0000_0000) ? SEED_SUBST : seed_i;
        end else if (adv_i) begin
            lfsr_r <= lfsr_adv32(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    assign state_o = lfsr_r;

endmodule

// File: rtl/dom_and_share_feeder.sv
// Splits operand pairs into two Boolean shares for a 2-share DOM AND gadget
// and sequences the gadget's one-cycle register latency.
module dom_and_share_feeder
    import dom_pkg::*;
#(
    parameter int          WIDTH        = 8,
    parameter logic [31:0] SEED_DEFAULT = 32'hC0FF_EE01,
    parameter logic [31:0] SEED_SUBST   = 32'h1357_9BDF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             seed_valid_i,
    input  logic [31:0]      seed_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    output logic [WIDTH-1:0] X0_o,
    output logic [WIDTH-1:0] X1_o,
    output logic [WIDTH-1:0] Y0_o,
    output logic [WIDTH-1:0] Y1_o,
    output logic [WIDTH-1:0] Z_o,
    output logic             dom_q_valid_o,
    output logic             busy_o
);

    state_t            state_r;
    state_t            next_state_s;
    logic              accept_s;
    logic [LFSR_W-1:0] lfsr_s;
    logic [WIDTH-1:0]  mx_s, my_s, mz_s;
    logic [WIDTH-1:0]  x0_r, x1_r, y0_r, y1_r, z_r;
    logic              dq_valid_r;
    logic              busy_r;
    logic              unused_lfsr_s;

    assign in_ready_o = ((state_r == IDLE) || (state_r == HOLD)) && !seed_valid_i && !rst_i;
    assign accept_s   = in_valid_i && in_ready_o;

    assign mx_s          = lfsr_s[WIDTH-1:0];
    assign my_s          = lfsr_s[2*WIDTH-1:WIDTH];
    assign mz_s          = lfsr_s[3*WIDTH-1:2*WIDTH];
    assign unused_lfsr_s = ^lfsr_s[LFSR_W-1:3*WIDTH];

    dom_lfsr32 #(
        .SEED_DEFAULT (SEED_DEFAULT),
        .SEED_SUBST   (SEED_SUBST)
    ) u_lfsr (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .seed_valid_i (seed_valid_i),
        .seed_i       (seed_i),
        .adv_i        (accept_s),
        .state_o      (lfsr_s)
    );

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state: ISSUE always moves to HOLD, where a new op may start at once.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = ISSUE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ISSUE: next_state_s = HOLD;
            HOLD: begin
                if (accept_s) begin
                    next_state_s = ISSUE;
                end else begin
                    next_state_s = IDLE;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Share and randomness registers: loaded only on accept so they stay stable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x0_r <= '0;
            x1_r <= '0;
            y0_r <= '0;
            y1_r <= '0;
            z_r  <= '0;
        end else if (accept_s) begin
            x0_r <= x_i ^ mx_s;
            x1_r <= mx_s;
            y0_r <= y_i ^ my_s;
            y1_r <= my_s;
            z_r  <= mz_s;
        end else begin
            x0_r <= x0_r;
            x1_r <= x1_r;
            y0_r <= y0_r;
            y1_r <= y1_r;
            z_r  <= z_r;
        end
    end

    // Status flags registered from the next state so they track the FSM exactly.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dq_valid_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            dq_valid_r <= (next_state_s == HOLD);
            busy_r     <= (next_state_s != IDLE);
        end
    end

    assign X0_o          = x0_r;
    assign X1_o          = x1_r;
    assign Y0_o          = y0_r;
    assign Y1_o          = y1_r;
    assign Z_o           = z_r;
    assign dom_q_valid_o = dq_valid_r;
    assign busy_o        = busy_r;

endmodule

// File: tb/tb_dom_and_share_feeder.sv
// Directed self-checking bench for dom_and_share_feeder.
module tb_dom_and_share_feeder;

    localparam logic [31:0] SEED_DEFAULT = 32'hC0FF_EE01;
    localparam logic [31:0] SEED_SUBST   = 32'h1357_9BDF;
    localparam logic [31:0] POLY         = 32'h8020_0003;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        seed_valid_i = 1'b0;
    logic [31:0] seed_i = 32'h0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [7:0]  x_i = 8'h0, y_i = 8'h0;
    logic [7:0]  X0_o, X1_o, Y0_o, Y1_o, Z_o;
    logic        dom_q_valid_o, busy_o;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] model_l;

    dom_and_share_feeder #(.WIDTH(8), .SEED_DEFAULT(SEED_DEFAULT), .SEED_SUBST(SEED_SUBST)) dut (
        .clk_i(clk), .rst_i(rst_i), .seed_valid_i(seed_valid_i), .seed_i(seed_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .x_i(x_i), .y_i(y_i),
        .X0_o(X0_o), .X1_o(X1_o), .Y0_o(Y0_o), .Y1_o(Y1_o), .Z_o(Z_o),
        .dom_q_valid_o(dom_q_valid_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_adv(input logic [31:0] l);
        logic [31:0] v;
        v = l;
        for (int i = 0; i < 32; i++) v = v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        step();
        n_vec++; if (in_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", in_ready_o); end
        n_vec++; if ({X0_o, X1_o, Y0_o, Y1_o, Z_o} !== 40'h0) begin n_err++; $display("FAIL reset_shares got %h want 0", {X0_o, X1_o, Y0_o, Y1_o, Z_o}); end
        n_vec++; if ({busy_o, dom_q_valid_o} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b want 00", {busy_o, dom_q_valid_o}); end
        rst_i   = 1'b0;
        model_l = SEED_DEFAULT;
        #1;
        n_vec++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL idle_ready got %b want 1", in_ready_o); end
    endtask

    task automatic test_first_op();
        x_i = 8'hA5; y_i = 8'h3C; in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        model_l = model_adv(model_l);
        n_vec++; if ({X0_o, X1_o, Y0_o, Y1_o, Z_o} !== 40'hA4_01_D2_EE_FF) begin n_err++; $display("FAIL first_shares got %h want a401d2eeff", {X0_o, X1_o, Y0_o, Y1_o, Z_o}); end
        n_vec++; if ({busy_o, dom_q_valid_o, in_ready_o} !== 3'b100) begin n_err++; $display("FAIL first_issue_flags got %b want 100", {busy_o, dom_q_valid_o, in_ready_o}); end
        step();
        n_vec++; if ({busy_o, dom_q_valid_o, in_ready_o} !== 3'b111) begin n_err++; $display("FAIL first_hold_flags got %b want 111", {busy_o, dom_q_valid_o, in_ready_o}); end
        n_vec++; if (((X0_o ^ X1_o) & (Y0_o ^ Y1_o)) !== 8'h24) begin n_err++; $display("FAIL first_and got %h want 24", (X0_o ^ X1_o) & (Y0_o ^ Y1_o)); end
        step();
        n_vec++; if ({busy_o, dom_q_valid_o} !== 2'b00) begin n_err++; $display("FAIL first_idle_flags got %b want 00", {busy_o, dom_q_valid_o}); end
        n_vec++; if ({X0_o, X1_o, Y0_o, Y1_o, Z_o} !== 40'hA4_01_D2_EE_FF) begin n_err++; $display("FAIL idle_retain got %h want a401d2eeff", {X0_o, X1_o, Y0_o, Y1_o, Z_o}); end
    endtask

    // Streams ops with in_valid held high; x/y come from the table or $urandom.
    task automatic test_back_to_back(input int nops, input bit rnd);
        logic [7:0] xs [6] = '{8'hFF, 8'h00, 8'h5A, 8'hF0, 8'h81, 8'h3C};
        logic [7:0] ys [6] = '{8'hFF, 8'hFF, 8'hA5, 8'h3C, 8'h7E, 8'hC3};
        logic [7:0] ex, ey;
        in_valid_i = 1'b1;
        for (int i = 0; i < nops; i++) begin
            ex = rnd ? 8'($urandom) : xs[i % 6];
            ey = rnd ? 8'($urandom) : ys[i % 6];
            x_i = ex; y_i = ey;
            #1;
            n_vec++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_ready op%0d got %b want 1", i, in_ready_o); end
            step();
            x_i = ~ex; y_i = ~ey;
            n_vec++; if ({X1_o, Y1_o, Z_o} !== {model_l[7:0], model_l[15:8], model_l[23:16]}) begin n_err++; $display("FAIL b2b_masks op%0d got %h want %h", i, {X1_o, Y1_o, Z_o}, {model_l[7:0], model_l[15:8], model_l[23:16]}); end
            n_vec++; if ({X0_o ^ X1_o, Y0_o ^ Y1_o} !== {ex, ey}) begin n_err++; $display("FAIL b2b_unmask op%0d got %h want %h", i, {X0_o ^ X1_o, Y0_o ^ Y1_o}, {ex, ey}); end
            n_vec++; if ({dom_q_valid_o, in_ready_o, busy_o} !== 3'b001) begin n_err++; $display("FAIL b2b_issue op%0d got %b want 001", i, {dom_q_valid_o, in_ready_o, busy_o}); end
            model_l = model_adv(model_l);
            step();
            n_vec++; if (dom_q_valid_o !== 1'b1) begin n_err++; $display("FAIL b2b_qvalid op%0d got %b want 1", i, dom_q_valid_o); end
            n_vec++; if (((X0_o ^ X1_o) & (Y0_o ^ Y1_o)) !== (ex & ey)) begin n_err++; $display("FAIL b2b_and op%0d got %h want %h", i, (X0_o ^ X1_o) & (Y0_o ^ Y1_o), ex & ey); end
        end
        in_valid_i = 1'b0;
        step();
        n_vec++; if ({busy_o, dom_q_valid_o} !== 2'b00) begin n_err++; $display("FAIL b2b_drain got %b want 00", {busy_o, dom_q_valid_o}); end
    endtask

    task automatic test_seed_zero();
        seed_valid_i = 1'b1; seed_i = 32'h0; in_valid_i = 1'b1; x_i = 8'h12; y_i = 8'h34;
        #1;
        n_vec++; if (in_ready_o !== 1'b0) begin n_err++; $display("FAIL seed_ready got %b want 0", in_ready_o); end
        step();
        seed_valid_i = 1'b0;
        n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL seed_no_accept got %b want 0", busy_o); end
        step();
        in_valid_i = 1'b0;
        n_vec++; if ({X0_o, X1_o, Y0_o, Y1_o, Z_o} !== 40'hCD_DF_AF_9B_57) begin n_err++; $display("FAIL seed_subst got %h want cddfaf9b57", {X0_o, X1_o, Y0_o, Y1_o, Z_o}); end
        model_l = model_adv(SEED_SUBST);
        step();
        step();
    endtask

    task automatic test_seed_in_hold();
        logic [39:0] held;
        x_i = 8'h0F; y_i = 8'hF0; in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        held = {X0_o, X1_o, Y0_o, Y1_o, Z_o};
        n_vec++; if (held[31:24] !== model_l[7:0]) begin n_err++; $display("FAIL hold_x1 got %h want %h", held[31:24], model_l[7:0]); end
        step();
        seed_valid_i = 1'b1; seed_i = 32'hDEAD_BEEF; in_valid_i = 1'b1;
        #1;
        n_vec++; if ({dom_q_valid_o, in_ready_o} !== 2'b10) begin n_err++; $display("FAIL hold_seed_flags got %b want 10", {dom_q_valid_o, in_ready_o}); end
        n_vec++; if ({X0_o, X1_o, Y0_o, Y1_o, Z_o} !== held) begin n_err++; $display("FAIL hold_stable got %h want %h", {X0_o, X1_o, Y0_o, Y1_o, Z_o}, held); end
        step();
        seed_valid_i = 1'b0;
        n_vec++; if ({busy_o, dom_q_valid_o} !== 2'b00) begin n_err++; $display("FAIL hold_seed_idle got %b want 00", {busy_o, dom_q_valid_o}); end
        step();
        in_valid_i = 1'b0;
        n_vec++; if ({X0_o, X1_o, Y0_o, Y1_o, Z_o} !== 40'hE0_EF_4E_BE_AD) begin n_err++; $display("FAIL new_seed_masks got %h want e0ef4ebead", {X0_o, X1_o, Y0_o, Y1_o, Z_o}); end
        model_l = model_adv(32'hDEAD_BEEF);
        step();
        step();
    endtask

    task automatic test_reset_abort();
        x_i = 8'h77; y_i = 8'h99; in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        rst_i = 1'b1;
        step();
        n_vec++; if ({X0_o, X1_o, Y0_o, Y1_o, Z_o, busy_o, dom_q_valid_o, in_ready_o} !== 43'h0) begin n_err++; $display("FAIL abort_clear got %h want 0", {X0_o, X1_o, Y0_o, Y1_o, Z_o, busy_o, dom_q_valid_o, in_ready_o}); end
        rst_i = 1'b0;
        step();
        n_vec++; if (dom_q_valid_o !== 1'b0) begin n_err++; $display("FAIL abort_qvalid got %b want 0", dom_q_valid_o); end
        x_i = 8'hA5; y_i = 8'h3C; in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        n_vec++; if ({X0_o, X1_o, Y0_o, Y1_o, Z_o} !== 40'hA4_01_D2_EE_FF) begin n_err++; $display("FAIL abort_restart got %h want a401d2eeff", {X0_o, X1_o, Y0_o, Y1_o, Z_o}); end
        model_l = model_adv(SEED_DEFAULT);
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_first_op();
        test_back_to_back(6, 1'b0);
        test_seed_zero();
        test_seed_in_hold();
        test_reset_abort();
        test_back_to_back(300, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
